mandel_job_scheduler: RTL and testbench

Frame-level controller that shares a pool of NUM_ENG Mandelbrot iteration engines across one 640x480 frame. It walks the pixel grid and dispatches per-pixel C coordinates to free engines. It round-robin arbitrates engine results onto the single frame-RAM write port (addrA/dinA/wea), and handles frame restart when the keypad logic issues a new view.

---
 rtl/mandel_job_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_mandel_job_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_job_scheduler.sv
// Frame controller for a pool of Mandelbrot engines: walks the pixel grid,
// dispatches C coordinates to idle engines, and funnels results to frame RAM.
module mandel_job_scheduler #(
  parameter int NUM_ENG = 4,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int AW      = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [63:0]           c_real_start,
  input  logic [63:0]           c_imag_start,
  input  logic [63:0]           step,
  output logic [NUM_ENG-1:0]    job_valid,
  input  logic [NUM_ENG-1:0]    job_ready,
  output logic [63:0]           job_c_real,
  output logic [63:0]           job_c_imag,
  output logic [AW-1:0]         job_addr,
  input  logic [NUM_ENG-1:0]    res_valid,
  output logic [NUM_ENG-1:0]    res_ready,
  input  logic [NUM_ENG*AW-1:0] res_addr,
  input  logic [NUM_ENG*12-1:0] res_color,
  output logic [AW-1:0]         addrA,
  output logic [11:0]           dinA,
  output logic                  wea,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int OW = $clog2(NUM_ENG) + 1;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FLUSH} state_t;

  // Handshakes: a transfer happens in any cycle where valid[i] and ready[i]
  // are both high; job_valid and res_ready are one-hot and never hold a cycle.
  state_t          state;
  logic [63:0]     st_real, st_imag, st_step;
  logic [63:0]     c_real, c_imag;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [PW-1:0]   issue_ptr, res_ptr;
  logic [OW-1:0]   outstanding;
  logic [PW:0]     job_pick, res_pick;
  logic [PW-1:0]   res_i;
  logic            issue, accept, last_pix, suppress;

  // Returns {found, index} of the first set request at or after ptr.
  function automatic logic [PW:0] rr_first(input logic [NUM_ENG-1:0] req,
                                           input logic [PW-1:0] ptr);
    logic [PW:0] r;
    int          idx;
    r = '0;
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_ENG) idx = idx - NUM_ENG;
      if (req[idx[PW-1:0]]) r = {1'b1, idx[PW-1:0]};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(NUM_ENG - 1)) ? '0 : p + PW'(1);
  endfunction

  assign job_pick = rr_first(job_ready, issue_ptr);
  assign res_pick = rr_first(res_valid, res_ptr);
  assign res_i    = res_pick[PW-1:0];
  assign issue    = (state == DISPATCH) && job_pick[PW];
  assign accept   = res_pick[PW];
  assign last_pix = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));
  // Results of an aborted frame, including one granted in the restart cycle, are never written.
  assign suppress = (state == FLUSH) || (start && (state == DISPATCH || state == DRAIN));

  always_comb begin
    job_valid = '0;
    res_ready = '0;
    if (!reset) begin
      if (issue)  job_valid[job_pick[PW-1:0]] = 1'b1;
      if (accept) res_ready[res_i] = 1'b1;
    end
  end

  assign job_c_real = c_real;
  assign job_c_imag = c_imag;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      st_real     <= '0;
      st_imag     <= '0;
      st_step     <= '0;
      c_real      <= '0;
      c_imag      <= '0;
      x           <= '0;
      y           <= '0;
      job_addr    <= '0;
      issue_ptr   <= '0;
      res_ptr     <= '0;
      outstanding <= '0;
      addrA       <= '0;
      dinA        <= '0;
      wea         <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      wea        <= accept && !suppress;
      if (accept) begin
        addrA   <= res_addr[int'(res_i)*AW +: AW];
        dinA    <= res_color[int'(res_i)*12 +: 12];
        res_ptr <= next_ptr(res_i);
      end

      if (issue && !accept)      outstanding <= outstanding + OW'(1);
      else if (!issue && accept) outstanding <= outstanding - OW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            st_real  <= c_real_start;
            st_imag  <= c_imag_start;
            st_step  <= step;
            c_real   <= c_real_start;
            c_imag   <= c_imag_start;
            x        <= '0;
            y        <= '0;
            job_addr <= '0;
            state    <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (issue) begin
            issue_ptr <= next_ptr(job_pick[PW-1:0]);
            job_addr  <= job_addr + AW'(1);
            if (x == XW'(H_RES - 1)) begin
              x      <= '0;
              y      <= y + YW'(1);
              c_real <= st_real;
              c_imag <= c_imag - st_step;
            end else begin
              x      <= x + XW'(1);
              c_real <= c_real + st_step;
            end
          end
          if (start) begin
            st_real <= c_real_start;
            st_imag <= c_imag_start;
            st_step <= step;
            state   <= FLUSH;
          end else if (issue && last_pix) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (start) begin
            st_real <= c_real_start;
            st_imag <= c_imag_start;
            st_step <= step;
            state   <= FLUSH;
          end else if (outstanding == '0 && !wea) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        FLUSH: begin
          if (start) begin
            st_real <= c_real_start;
            st_imag <= c_imag_start;
            st_step <= step;
          end else if (outstanding == '0) begin
            c_real   <= st_real;
            c_imag   <= st_imag;
            x        <= '0;
            y        <= '0;
            job_addr <= '0;
            state    <= DISPATCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_job_scheduler.sv
// Bench for mandel_job_scheduler on a 4x2 frame with four modelled engines:
// arbitration vector table, directed frame/stall/restart/reset sequences, random frames.
module tb_mandel_job_scheduler;

  localparam int NE   = 4;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int AW   = 3;
  localparam int NPIX = H * V;

  logic               clk, reset, start;
  logic [63:0]        c_real_start, c_imag_start, step;
  logic [NE-1:0]      job_valid, job_ready, res_valid, res_ready;
  logic [63:0]        job_c_real, job_c_imag;
  logic [AW-1:0]      job_addr, addrA;
  logic [NE*AW-1:0]   res_addr;
  logic [NE*12-1:0]   res_color;
  logic [11:0]        dinA;
  logic               wea, busy, frame_done;

  mandel_job_scheduler #(.NUM_ENG(NE), .H_RES(H), .V_RES(V), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .c_real_start(c_real_start), .c_imag_start(c_imag_start), .step(step),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_c_real(job_c_real), .job_c_imag(job_c_imag), .job_addr(job_addr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_addr(res_addr), .res_color(res_color),
    .addrA(addrA), .dinA(dinA), .wea(wea), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit             eng_busy[NE], eng_done[NE], eng_stale[NE], eng_en[NE], res_hold[NE];
  int             eng_cnt[NE];
  logic [AW-1:0]  eng_addr[NE];
  logic [11:0]    eng_col[NE];
  int             lat_min = 3, lat_max = 3;
  logic [63:0]    f_cr, f_ci, f_st;
  int             exp_idx, issue_ptr, res_ptr, done_cnt, old_pending;
  bit             frame_active, in_flush;
  int             written[NPIX];
  logic [AW+11:0] exp_q[$];

  typedef struct {
    logic [NE-1:0] rv;
    logic [NE-1:0] rr;
    bit            w;
    logic [AW-1:0] a;
    logic [11:0]   d;
  } arb_vec_t;
  arb_vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_cr(input int k);
    return f_cr + 64'(k % H) * f_st;
  endfunction

  function automatic logic [63:0] exp_ci(input int k);
    return f_ci - 64'(k / H) * f_st;
  endfunction

  function automatic logic [NE-1:0] rr_pick(input logic [NE-1:0] req, input int ptr);
    logic [NE-1:0] r;
    r = '0;
    for (int k = 0; k < NE; k++)
      if (req[(ptr + k) % NE]) begin
        r[(ptr + k) % NE] = 1'b1;
        return r;
      end
    return r;
  endfunction

  function automatic int onehot_idx(input logic [NE-1:0] v);
    for (int i = 0; i < NE; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NE; i++) begin
      eng_busy[i] = 0; eng_done[i] = 0; eng_stale[i] = 0; eng_cnt[i] = 0;
      eng_addr[i] = '0; eng_col[i] = '0;
    end
    for (int p = 0; p < NPIX; p++) written[p] = 0;
    exp_q.delete();
    exp_idx = 0; issue_ptr = 0; res_ptr = 0; old_pending = 0;
    frame_active = 0; in_flush = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; job_ready = '1; res_valid = '0;
    @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_wea", wea, 0);
    chk("reset_job_valid", job_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_job_addr", job_addr, 0);
    reset = 1'b0; job_ready = '0;
    clear_model();
    @(negedge clk);
  endtask

  // One clock cycle: drive engines, check dispatch/grant, then check the registered write.
  task automatic tick(input bit do_start, input logic [63:0] ncr, input logic [63:0] nci,
                      input logic [63:0] nst);
    logic [NE-1:0]  exp_j, exp_g;
    logic [63:0]    cr_t, ci_t;
    logic [AW+11:0] e;
    int             idx, stale_n;
    bit             dispatching, exp_w, ok;
    stale_n = 0;
    for (int i = 0; i < NE; i++) begin
      if (eng_stale[i]) stale_n++;
      if (eng_busy[i] && !eng_done[i]) begin
        if (eng_cnt[i] > 0) eng_cnt[i]--;
        if (eng_cnt[i] == 0) eng_done[i] = 1;
      end
      job_ready[i] = eng_en[i] && !eng_busy[i];
      res_valid[i] = eng_done[i] && !res_hold[i];
      res_addr[i*AW +: AW]  = eng_addr[i];
      res_color[i*12 +: 12] = eng_col[i];
    end
    start = do_start;
    if (do_start) begin
      c_real_start = ncr; c_imag_start = nci; step = nst;
    end
    #1;
    dispatching = frame_active && !in_flush && (exp_idx < NPIX);
    exp_j = dispatching ? rr_pick(job_ready, issue_ptr) : '0;
    chk("job_valid", job_valid, exp_j);
    if (dispatching) begin
      cr_t = exp_cr(exp_idx);
      ci_t = exp_ci(exp_idx);
      chk("job_addr", job_addr, exp_idx);
      chk("job_c_real", job_c_real, cr_t);
      chk("job_c_imag", job_c_imag, ci_t);
      if (exp_j != '0) begin
        idx = onehot_idx(exp_j);
        eng_busy[idx] = 1; eng_done[idx] = 0; eng_stale[idx] = 0;
        eng_cnt[idx]  = $urandom_range(lat_max, lat_min);
        eng_addr[idx] = AW'(exp_idx);
        eng_col[idx]  = {ci_t[3:0], cr_t[4:0], eng_addr[idx]};
        issue_ptr = (idx + 1) % NE;
        exp_idx++;
      end
    end
    if (do_start) begin
      if (frame_active) begin
        for (int i = 0; i < NE; i++) if (eng_busy[i]) eng_stale[i] = 1;
        in_flush = 1;
      end
      frame_active = 1;
      f_cr = ncr; f_ci = nci; f_st = nst;
      exp_idx = 0;
      old_pending = exp_q.size();
      for (int p = 0; p < NPIX; p++) written[p] = 0;
    end
    exp_g = rr_pick(res_valid, res_ptr);
    chk("res_ready", res_ready, exp_g);
    if (exp_g != '0) begin
      idx = onehot_idx(exp_g);
      if (!eng_stale[idx]) exp_q.push_back({eng_addr[idx], eng_col[idx]});
      eng_busy[idx] = 0; eng_done[idx] = 0; eng_stale[idx] = 0;
      res_ptr = (idx + 1) % NE;
    end
    if (in_flush && stale_n == 0 && !do_start) in_flush = 0;

    @(posedge clk); #1;
    start = 1'b0;
    exp_w = (exp_q.size() != 0);
    chk("wea", wea, exp_w);
    if (exp_w) begin
      e = exp_q.pop_front();
      chk("addrA", addrA, e[AW+11:12]);
      chk("dinA", dinA, e[11:0]);
      if (old_pending > 0) old_pending--;
      else written[addrA]++;
    end
    if (frame_done) begin
      ok = frame_active && !in_flush && (exp_idx == NPIX) && (exp_q.size() == 0);
      for (int i = 0; i < NE; i++) if (eng_busy[i]) ok = 0;
      for (int p = 0; p < NPIX; p++) if (written[p] != 1) ok = 0;
      chk("frame_done_ok", ok, 1);
      frame_active = 0;
      done_cnt++;
    end
    chk("busy", busy, frame_active);
    @(negedge clk);
  endtask

  task automatic run_frames(input int target, input int budget, input bit rnd);
    int cyc;
    cyc = 0;
    while (done_cnt < target && cyc < budget) begin
      if (rnd) begin
        for (int i = 0; i < NE; i++) begin
          eng_en[i]   = ($urandom_range(3, 0) != 0);
          res_hold[i] = ($urandom_range(4, 0) == 0);
        end
      end
      if (rnd && frame_active && $urandom_range(59, 0) == 0)
        tick(1, rnd64(), rnd64(), rnd64());
      else
        tick(0, '0, '0, '0);
      cyc++;
    end
    chk("frames_completed", done_cnt, target);
  endtask

  task automatic run_to_idx(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (exp_idx < n && cyc < budget) begin
      tick(0, '0, '0, '0);
      cyc++;
    end
    chk("reach_idx", exp_idx, n);
  endtask

  task automatic set_en(input logic [NE-1:0] m);
    for (int i = 0; i < NE; i++) begin
      eng_en[i] = m[i];
      res_hold[i] = 0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    c_real_start = '0; c_imag_start = '0; step = '0;
    job_ready = '0; res_valid = '0; res_addr = '0; res_color = '0;
    done_cnt = 0;
    set_en('0);
    clear_model();
    do_reset();

    // Result arbitration in IDLE: engine i offers addr 2i+1, colour A00+i.
    tbl[0]  = '{4'b1111, 4'b0001, 1, 3'd1, 12'hA00};
    tbl[1]  = '{4'b1111, 4'b0010, 1, 3'd3, 12'hA01};
    tbl[2]  = '{4'b1111, 4'b0100, 1, 3'd5, 12'hA02};
    tbl[3]  = '{4'b1111, 4'b1000, 1, 3'd7, 12'hA03};
    tbl[4]  = '{4'b1111, 4'b0001, 1, 3'd1, 12'hA00};
    tbl[5]  = '{4'b0101, 4'b0100, 1, 3'd5, 12'hA02};
    tbl[6]  = '{4'b0011, 4'b0001, 1, 3'd1, 12'hA00};
    tbl[7]  = '{4'b0000, 4'b0000, 0, 3'd0, 12'h000};
    tbl[8]  = '{4'b1000, 4'b1000, 1, 3'd7, 12'hA03};
    tbl[9]  = '{4'b0110, 4'b0010, 1, 3'd3, 12'hA01};
    tbl[10] = '{4'b0011, 4'b0001, 1, 3'd1, 12'hA00};
    for (int i = 0; i < NE; i++) begin
      res_addr[i*AW +: AW]  = AW'(2 * i + 1);
      res_color[i*12 +: 12] = 12'hA00 + 12'(i);
    end
    for (int t = 0; t < 11; t++) begin
      res_valid = tbl[t].rv;
      #1;
      chk("tbl_res_ready", res_ready, tbl[t].rr);
      @(posedge clk); #1;
      chk("tbl_wea", wea, tbl[t].w);
      if (tbl[t].w) begin
        chk("tbl_addrA", addrA, tbl[t].a);
        chk("tbl_dinA", dinA, tbl[t].d);
      end
      @(negedge clk);
    end
    res_valid = '0;
    do_reset();

    // Full frame on two engines with fixed latency 3, origin 0, step 1.
    set_en(4'b0011);
    tick(1, 64'd0, 64'd0, 64'd1);
    run_frames(1, 200, 0);

    // Stall dispatch for 10 cycles after 3 jobs.
    set_en(4'b1111);
    tick(1, rnd64(), rnd64(), rnd64());
    run_to_idx(3, 50);
    set_en(4'b0000);
    repeat (10) tick(0, '0, '0, '0);
    set_en(4'b1111);
    run_frames(done_cnt + 1, 200, 0);

    // Restart with step 2 after 5 jobs; old results must not be written.
    tick(1, 64'd100, 64'd50, 64'd1);
    run_to_idx(5, 50);
    tick(1, 64'd7, 64'd3, 64'd2);
    run_frames(done_cnt + 1, 200, 0);

    // Restart while draining the last results.
    tick(1, rnd64(), rnd64(), rnd64());
    run_to_idx(NPIX, 100);
    tick(1, rnd64(), rnd64(), rnd64());
    run_frames(done_cnt + 1, 200, 0);

    // Reset in the middle of dispatch, then a clean frame from addr 0.
    tick(1, rnd64(), rnd64(), rnd64());
    run_to_idx(3, 50);
    do_reset();
    set_en(4'b1111);
    tick(1, rnd64(), rnd64(), rnd64());
    run_frames(done_cnt + 1, 200, 0);

    // Random engine availability, latencies, result back-pressure and restarts.
    lat_min = 1; lat_max = 5;
    for (int f = 0; f < 8; f++) begin
      tick(1, rnd64(), rnd64(), rnd64());
      run_frames(done_cnt + 1, 600, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
